uart_cmd_responder: RTL and testbench
=====================================

# uart_cmd_responder

Byte-level command responder on the host side of the UART FIFO interface. It drains received bytes from the RX FIFO read port (rd_uart/rx_empty/r_data), parses a fixed framed protocol (register write / register read), executes against an internal bank of 8-bit registers, and pushes one response byte per frame into the TX FIFO write port (wr_uart/w_data/tx_full). It turns the UART into a remote register-access port.

## Interface
- n_regs, 16: number of 8-bit registers; valid addresses 0..n_regs-1, 1 <= n_regs <= 256.
- timeout_cycles, 100000: inter-byte timeout in clk cycles, applied inside a frame only.
- n_timeout, 17: counter width; must satisfy 2^n_timeout > timeout_cycles.
- clk  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-low reset.
- rx_empty  in  1  RX FIFO empty flag.
- r_data  in  8  RX FIFO data; valid one cycle after rd_uart.
- rd_uart  out  1  RX FIFO read strobe.
- tx_full  in  1  TX FIFO full flag.
- wr_uart  out  1  TX FIFO write strobe.
- w_data  out  8  TX FIFO write data.
- reg_out  out  8*n_regs  flat register contents; reg k occupies bits [8k+7:8k].
- reg_wr_tick  out  1  one-cycle pulse on each register write.
- reg_wr_addr  out  8  address of the last write; valid with reg_wr_tick.
- frame_err  out  1  one-cycle pulse on a bad opcode, bad address or timeout.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- Frames: write = 0x57 ('W'), addr, data → response 0x4B ('K'). Read = 0x52 ('R'), addr → response reg[addr].
- Any other opcode → response 0x45 ('E') plus frame_err. No further bytes are consumed for that frame.
- Address >= n_regs → response 'E' plus frame_err. A write frame still consumes its data byte, and no register changes.
- States: IDLE, OP_LAT, ADDR_WAIT, ADDR_LAT, DATA_WAIT, DATA_LAT, RESP.
- IDLE/ADDR_WAIT/DATA_WAIT: rd_uart = ~rx_empty (combinational). On a read, the next state is the matching *_LAT state.
- *_LAT states: capture r_data.
  - OP_LAT: goes to ADDR_WAIT for 'W'/'R', otherwise to RESP('E').
  - ADDR_LAT: a read goes to RESP with the data or 'E'; a write goes to DATA_WAIT.
  - DATA_LAT: performs the write if the address is valid, then goes to RESP('K' or 'E').
- RESP: wr_uart = ~tx_full (combinational), w_data = registered response byte. Moves to IDLE on the cycle wr_uart is high. While tx_full=1 it holds, and no RX bytes are read.
- Timeout: the counter clears on entry to ADDR_WAIT/DATA_WAIT and increments each cycle rx_empty=1. When count == timeout_cycles-1 with rx_empty=1, go to IDLE, pulse frame_err, send no response, and discard the partial frame.
- rd_uart and wr_uart are never high in the same cycle. At most one byte is in flight per direction.

## Timing
- Reset (asynchronous assert) values: state IDLE, rd_uart 0, wr_uart 0, w_data 0x00, all registers 0x00, reg_wr_tick 0, reg_wr_addr 0x00, frame_err 0, busy 0, timeout counter 0.
- Reset mid-frame: the partial frame is dropped and no response is sent. Bytes already in the RX FIFO are parsed afresh as new frames after release.
- Byte fetch: rd_uart is high in cycle t, r_data is captured in cycle t+1 (the *_LAT state).
- Response latency: wr_uart rises in cycle t+2 (t = cycle of rd_uart for the frame's last byte), provided tx_full=0.
- Register write: the register updates at the edge ending DATA_LAT and is visible on reg_out in cycle t+2. reg_wr_tick and reg_wr_addr are registered and high in cycle t+2.
- frame_err is registered: high the cycle after the decision state, for one cycle.
- A byte arriving in the cycle the timeout expires wins: it is read and the timeout is cancelled.
- Back-to-back frames: the next opcode can be read the cycle after wr_uart. Minimum frame period is 7 cycles for a write and 5 for a read.
- Address compare is unsigned over the full 8 bits.

## Test plan
- Write 0x57,0x03,0xA5 with the RX FIFO model at 1-cycle latency → reg_out[31:24]=0xA5, reg_wr_tick pulse with reg_wr_addr=0x03, w_data=0x4B written 2 cycles after the third rd_uart.
- After the write above, send 0x52,0x03 → a single wr_uart with w_data=0xA5; 0x52,0x07 → 0x00.
- Send 0x52,0x10 (n_regs=16) → 'E' (0x45) and a frame_err pulse. Send 0x57,0x20,0x11 → three bytes consumed, 'E', no reg_wr_tick, registers unchanged.
- Send 0x41 → 'E' immediately, frame_err pulse. A following 0x52,0x00 → 0x00, confirming the parser is back in sync.
- Send 0x57,0x01 then stall the RX FIFO with timeout_cycles=50 → return to IDLE 50 cycles after entering DATA_WAIT, frame_err pulse, nothing written to TX. Also send a byte exactly at cycle 49 → it is accepted.
- Hold tx_full=1 during a read response → the block stays in RESP, rd_uart stays 0, busy stays 1. Release → one wr_uart. Assert reset mid-frame → all outputs reach their reset values asynchronously.

Source files
------------

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: framed register read/write responder between a UART RX FIFO and a UART TX FIFO.
//   clk, reset (async, active-low)
//   rx_empty/r_data/rd_uart   : RX FIFO read port, r_data valid the cycle after rd_uart
//   tx_full/wr_uart/w_data    : TX FIFO write port
//   reg_out                   : flat register bank, reg k at [8k+7:8k]
//   reg_wr_tick/reg_wr_addr   : registered write notification
//   frame_err                 : one-cycle pulse on bad opcode, bad address or inter-byte timeout
//   busy                      : high outside IDLE
module uart_cmd_responder #(
  parameter int n_regs = 16,
  parameter int timeout_cycles = 100000,
  parameter int n_timeout = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_empty,
  input  logic [7:0]            r_data,
  output logic                  rd_uart,
  input  logic                  tx_full,
  output logic                  wr_uart,
  output logic [7:0]            w_data,
  output logic [8*n_regs-1:0]   reg_out,
  output logic                  reg_wr_tick,
  output logic [7:0]            reg_wr_addr,
  output logic                  frame_err,
  output logic                  busy
);
  typedef enum logic [2:0] {IDLE, OP_LAT, ADDR_WAIT, ADDR_LAT, DATA_WAIT, DATA_LAT, RESP} state_t;
  localparam logic [7:0] op_w = 8'h57;
  localparam logic [7:0] op_r = 8'h52;
  localparam logic [7:0] rsp_k = 8'h4B;
  localparam logic [7:0] rsp_e = 8'h45;
  localparam logic [n_timeout-1:0] cnt_max = n_timeout'(timeout_cycles - 1);
  localparam logic [8:0] regs_lim = 9'(n_regs);
  state_t state_q, state_d;
  logic [n_timeout-1:0] cnt_q, cnt_d;
  logic is_wr_q, is_wr_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] resp_q, resp_d;
  logic tick_q, tick_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic err_q, err_d;
  logic [7:0] regs_q [n_regs];
  logic [7:0] regs_d [n_regs];
  logic [7:0] rd_mux;
  logic r_addr_ok, q_addr_ok;
  // Compare over 9 bits so n_regs = 256 still accepts every 8-bit address.
  assign r_addr_ok = {1'b0, r_data} < regs_lim;
  assign q_addr_ok = {1'b0, addr_q} < regs_lim;
  // Read data is selected by the address byte as it is latched, so the response is ready in RESP.
  always_comb begin
    rd_mux = 8'h00;
    for (int k = 0; k < n_regs; k++)
      if (r_data == 8'(k)) rd_mux = regs_q[k];
  end
  // rd_uart is gated by reset so nothing is pulled from the FIFO while held in reset.
  assign rd_uart = reset && !rx_empty && (state_q == IDLE || state_q == ADDR_WAIT || state_q == DATA_WAIT);
  assign wr_uart = (state_q == RESP) && !tx_full;
  assign w_data = resp_q;
  assign reg_wr_tick = tick_q;
  assign reg_wr_addr = wr_addr_q;
  assign frame_err = err_q;
  assign busy = state_q != IDLE;
  for (genvar k = 0; k < n_regs; k++) begin : g_out
    assign reg_out[8*k +: 8] = regs_q[k];
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    is_wr_d = is_wr_q;
    addr_d = addr_q;
    resp_d = resp_q;
    tick_d = 1'b0;
    wr_addr_d = wr_addr_q;
    err_d = 1'b0;
    regs_d = regs_q;
    case (state_q)
      IDLE: state_d = rd_uart ? OP_LAT : IDLE;
      OP_LAT: begin
        is_wr_d = r_data == op_w;
        cnt_d = '0;
        state_d = (r_data == op_w || r_data == op_r) ? ADDR_WAIT : RESP;
        resp_d = (r_data == op_w || r_data == op_r) ? resp_q : rsp_e;
        err_d = !(r_data == op_w || r_data == op_r);
      end
      ADDR_WAIT, DATA_WAIT: begin
        // An arriving byte takes priority over an expiring timeout.
        if (!rx_empty) state_d = (state_q == ADDR_WAIT) ? ADDR_LAT : DATA_LAT;
        else if (cnt_q == cnt_max) begin
          state_d = IDLE;
          err_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      ADDR_LAT: begin
        addr_d = r_data;
        cnt_d = '0;
        state_d = is_wr_q ? DATA_WAIT : RESP;
        resp_d = is_wr_q ? resp_q : (r_addr_ok ? rd_mux : rsp_e);
        err_d = !is_wr_q && !r_addr_ok;
      end
      DATA_LAT: begin
        for (int k = 0; k < n_regs; k++)
          if (q_addr_ok && addr_q == 8'(k)) regs_d[k] = r_data;
        tick_d = q_addr_ok;
        wr_addr_d = q_addr_ok ? addr_q : wr_addr_q;
        resp_d = q_addr_ok ? rsp_k : rsp_e;
        err_d = !q_addr_ok;
        state_d = RESP;
      end
      RESP: state_d = tx_full ? RESP : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      is_wr_q <= 1'b0;
      addr_q <= 8'h00;
      resp_q <= 8'h00;
      tick_q <= 1'b0;
      wr_addr_q <= 8'h00;
      err_q <= 1'b0;
      regs_q <= '{default: 8'h00};
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      is_wr_q <= is_wr_d;
      addr_q <= addr_d;
      resp_q <= resp_d;
      tick_q <= tick_d;
      wr_addr_q <= wr_addr_d;
      err_q <= err_d;
      regs_q <= regs_d;
    end
  end
endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb_uart_cmd_responder: directed frames through FIFO models with a queued scoreboard on the TX side.
module tb_uart_cmd_responder;
  localparam int nr = 16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic rd_uart;
  logic tx_full = 1'b0;
  logic wr_uart;
  logic [7:0] w_data;
  logic [8*nr-1:0] reg_out;
  logic reg_wr_tick;
  logic [7:0] reg_wr_addr;
  logic frame_err;
  logic busy;
  uart_cmd_responder #(.n_regs(nr), .timeout_cycles(50), .n_timeout(6)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .reg_out(reg_out),
    .reg_wr_tick(reg_wr_tick), .reg_wr_addr(reg_wr_addr), .frame_err(frame_err), .busy(busy)
  );
  always #5 clk = ~clk;
  logic [7:0] rxq[$];
  logic [7:0] expq[$];
  int errors = 0, checks = 0, cyc = 0;
  int rd_cnt = 0, wr_cnt = 0, tick_cnt = 0, err_cnt = 0;
  int last_rd_cyc = 0, last_lat = 0, last_err_cyc = 0;
  logic [7:0] tick_addr = 8'h00;
  always @(posedge clk) begin
    cyc++;
    if (rd_uart) r_data <= rxq.pop_front();
    rx_empty <= rxq.size() == 0;
  end
  always @(negedge clk) if (reset) begin
    if (rd_uart) begin
      rd_cnt++;
      last_rd_cyc = cyc;
    end
    if (wr_uart) begin
      logic [7:0] e;
      wr_cnt++;
      last_lat = cyc - last_rd_cyc;
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected: wrote 0x%02h, none required", w_data);
      end else begin
        e = expq.pop_front();
        if (w_data !== e) begin
          errors++;
          $display("FAIL tx_byte: got 0x%02h, required 0x%02h", w_data, e);
        end
      end
    end
    if (rd_uart && wr_uart) begin
      checks++;
      errors++;
      $display("FAIL rd_wr_overlap: rd_uart=1 wr_uart=1, required not both");
    end
    if (reg_wr_tick) begin
      tick_cnt++;
      tick_addr = reg_wr_addr;
    end
    if (frame_err) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
  end
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drain(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      ok = rxq.size() == 0 && !busy && expq.size() == 0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_%s: rx=%0d exp=%0d busy=%0b, required all idle", nm, rxq.size(), expq.size(), busy);
    end
    tick();
  endtask
  task automatic wait_rd(input int target);
    for (int i = 0; i < 100 && rd_cnt < target; i++) tick();
    chk("rd_count", 128'(rd_cnt), 128'(target));
  endtask
  task automatic check_reset(input string nm);
    chk({nm, "_rd_uart"}, 128'(rd_uart), 128'(0));
    chk({nm, "_wr_uart"}, 128'(wr_uart), 128'(0));
    chk({nm, "_w_data"}, 128'(w_data), 128'(0));
    chk({nm, "_reg_out"}, reg_out, 128'(0));
    chk({nm, "_tick"}, 128'(reg_wr_tick), 128'(0));
    chk({nm, "_wr_addr"}, 128'(reg_wr_addr), 128'(0));
    chk({nm, "_frame_err"}, 128'(frame_err), 128'(0));
    chk({nm, "_busy"}, 128'(busy), 128'(0));
  endtask
  initial begin
    int t, b_err, b_wr, b_tick;
    logic [127:0] snap;
    repeat (3) tick();
    check_reset("por");
    reset = 1'b1;
    tick();
    rxq.push_back(8'h57); rxq.push_back(8'h03); rxq.push_back(8'hA5);
    expq.push_back(8'h4B);
    drain("write");
    chk("w_reg3", reg_out[31:24], 128'hA5);
    chk("w_tick_cnt", 128'(tick_cnt), 128'(1));
    chk("w_tick_addr", 128'(tick_addr), 128'h03);
    chk("w_latency", 128'(last_lat), 128'(2));
    rxq.push_back(8'h52); rxq.push_back(8'h03); expq.push_back(8'hA5);
    rxq.push_back(8'h52); rxq.push_back(8'h07); expq.push_back(8'h00);
    drain("reads");
    chk("r_latency", 128'(last_lat), 128'(2));
    b_err = err_cnt;
    b_tick = tick_cnt;
    snap = reg_out;
    rxq.push_back(8'h52); rxq.push_back(8'h10); expq.push_back(8'h45);
    rxq.push_back(8'h57); rxq.push_back(8'h20); rxq.push_back(8'h11); expq.push_back(8'h45);
    drain("bad_addr");
    chk("ba_err_cnt", 128'(err_cnt), 128'(b_err + 2));
    chk("ba_tick_cnt", 128'(tick_cnt), 128'(b_tick));
    chk("ba_regs", reg_out, snap);
    b_err = err_cnt;
    rxq.push_back(8'h41); expq.push_back(8'h45);
    rxq.push_back(8'h52); rxq.push_back(8'h00); expq.push_back(8'h00);
    drain("bad_op");
    chk("bo_err_cnt", 128'(err_cnt), 128'(b_err + 1));
    b_err = err_cnt;
    b_wr = wr_cnt;
    t = rd_cnt;
    rxq.push_back(8'h57); rxq.push_back(8'h01);
    wait_rd(t + 2);
    t = last_rd_cyc;
    drain("timeout");
    chk("to_err_cnt", 128'(err_cnt), 128'(b_err + 1));
    chk("to_err_cycle", 128'(last_err_cyc - t), 128'(52));
    chk("to_no_tx", 128'(wr_cnt), 128'(b_wr));
    b_err = err_cnt;
    t = rd_cnt;
    rxq.push_back(8'h57); rxq.push_back(8'h01); expq.push_back(8'h4B);
    wait_rd(t + 2);
    t = last_rd_cyc;
    for (int i = 0; i < 100 && cyc < t + 50; i++) tick();
    rxq.push_back(8'h22);
    drain("late_byte");
    chk("lb_err_cnt", 128'(err_cnt), 128'(b_err));
    chk("lb_reg1", reg_out[15:8], 128'h22);
    chk("lb_tick_addr", 128'(tick_addr), 128'h01);
    tx_full = 1'b1;
    b_wr = wr_cnt;
    rxq.push_back(8'h52); rxq.push_back(8'h03); rxq.push_back(8'h52); expq.push_back(8'hA5);
    repeat (12) tick();
    chk("hold_busy", 128'(busy), 128'(1));
    chk("hold_rd_uart", 128'(rd_uart), 128'(0));
    chk("hold_wr_uart", 128'(wr_uart), 128'(0));
    chk("hold_rx_left", 128'(rxq.size()), 128'(1));
    chk("hold_wr_cnt", 128'(wr_cnt), 128'(b_wr));
    tx_full = 1'b0;
    tick();
    chk("rel_wr_cnt", 128'(wr_cnt), 128'(b_wr + 1));
    rxq.push_back(8'h00); expq.push_back(8'h00);
    drain("release");
    t = rd_cnt;
    rxq.push_back(8'h57); rxq.push_back(8'h05);
    wait_rd(t + 2);
    tick();
    chk("mid_busy", 128'(busy), 128'(1));
    #2 reset = 1'b0;
    #1 check_reset("async");
    tick();
    rxq.push_back(8'h52); rxq.push_back(8'h03); expq.push_back(8'h00);
    repeat (3) tick();
    chk("rst_rx_held", 128'(rxq.size()), 128'(2));
    reset = 1'b1;
    drain("after_reset");
    chk("final_regs", reg_out, 128'(0));
    chk("final_exp_empty", 128'(expq.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
